munoc_mni_resp_axi_adapter: RTL and testbench
=============================================

// Module: munoc_mni_resp_axi_adapter
// PURPOSE
//  Sits directly downstream of the master-side NoC response decoder. Consumes decoded B and R responses
//  and drives the AXI B/R channels of the attached master. Buffers each channel in a 2-entry skid slice.
//  Tracks AR burst lengths in a FIFO and generates RLAST from a per-burst beat counter.
// PARAMETERS
//  BW_ID      4   AXI ID width
//  BW_DATA    32  AXI R data width
//  BW_LEN     8   AXI ARLEN width
//  LEN_DEPTH  4   burst-length FIFO entries; must be a power of 2 and >= 2
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous, active-high reset
//  ar_fire    in   1        master AR handshake completed this cycle
//  ar_len     in   BW_LEN   ARLEN of that AR (beats-1)
//  ar_allow   out  1        low when the length FIFO is full; gates the master's ARREADY
//  dec_bvalid in   1        decoded B response valid
//  dec_bready out  1        adapter can accept a B response
//  dec_bid    in   BW_ID    B ID
//  dec_bresp  in   2        B RESP
//  dec_rvalid in   1        decoded R beat valid
//  dec_rready out  1        adapter can accept an R beat
//  dec_rid    in   BW_ID    R ID
//  dec_rresp  in   2        R RESP
//  dec_rdata  in   BW_DATA  R data
//  bvalid/bready/bid/bresp                 out/in/out/out  AXI B channel
//  rvalid/rready/rid/rresp/rdata/rlast     out/in/out/out/out/out  AXI R channel
//  proto_err  out  1        sticky: R beat received while the length FIFO was empty
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - bvalid=rvalid=0, proto_err=0.
//   - Both skid slices empty; length FIFO empty (ar_allow=1); beat counter 0.
//  Skid slices (B and R, identical):
//   - dec_xready = slice not full.
//   - Accept on dec_xvalid & dec_xready.
//   - Output entry is presented the cycle after accept (latency 1).
//   - Output holds stable while xvalid & !xready.
//   - Simultaneous accept and drain with 1 entry held: occupancy stays 1, order preserved.
//   - Full throughput: 1 beat/cycle when xready=1.
//  Length FIFO:
//   - Push ar_len on ar_fire. ar_fire while full is ignored; it must not occur because ar_allow=0.
//   - Pop when the R beat marked last is accepted into the R slice.
//   - Simultaneous push and pop is legal at any occupancy, including full (occupancy unchanged).
//   - ar_allow = !full, combinational from registered occupancy.
//   - Pointers wrap modulo LEN_DEPTH.
//  RLAST generation at R-slice accept, head = FIFO head:
//   - last = (beat_cnt == head).
//   - beat_cnt increments on each accepted beat and clears to 0 on a last beat.
//   - beat_cnt is BW_LEN bits.
//   - last is stored in the slice with the beat and drives rlast.
//  Boundary cases:
//   - FIFO empty at R accept: beat forced last=1, no pop, beat_cnt stays 0, proto_err sets.
//     proto_err is cleared only by rst.
//   - ARLEN=0: the first beat is last.
//  B and R paths are fully independent; no ordering between them.
//  Reset mid-burst discards slice contents, FIFO and beat_cnt; outputs drop on the next cycle.
//  No combinational path from rready/bready to dec_rready/dec_bready; both are registered-state based.
// CONFIGURATION
//  MUNOC_RESP_ADAPTER_ERRCNT_EN
//   - Defined: adds output err_cnt [15:0] and input err_clr.
//   - err_cnt increments once per beat delivered on the AXI B or R channel (valid&ready) with RESP[1]=1
//     (SLVERR/DECERR).
//   - err_cnt saturates at 16'hFFFF. A B and an R error in the same cycle add 2, saturating.
//   - err_clr zeroes err_cnt; clear has priority over same-cycle increments.
//   - rst zeroes err_cnt.
//   - Undefined: neither port exists; no counter logic.
// TESTING
//  1. Reset, then ar_len=3, then 4 R beats with rready=1 -> rdata in order; rlast=1 only on beat 4;
//     ar_allow=1 throughout.
//  2. ar_len=0 x4 (LEN_DEPTH=4) -> ar_allow=0 after the 4th push.
//     First single-beat R accepted -> ar_allow=1 the next cycle.
//  3. rready held 0 while 3 beats are offered -> dec_rready=0 after 2 accepted; rdata stable.
//     Then rready=1 -> beats delivered in order with no loss or duplication.
//  4. R beat with no prior AR -> rlast=1, proto_err=1 and held until rst.
//  5. Full FIFO, ar_fire coincides with the last-beat pop -> occupancy stays 4.
//     Next burst's rlast is positioned at the new length.
//  6. ERRCNT_EN: B resp=2'b10 and R resp=2'b11 delivered in the same cycle -> err_cnt=2;
//     err_clr with a same-cycle error -> err_cnt=0.

Source files
------------

// File: rtl/munoc_mni_resp_axi_adapter_if.sv
// rtl/munoc_mni_resp_axi_adapter_if.sv - bus bundle for the MNI response-to-AXI adapter
// Purpose: groups the AR bookkeeping, decoded B/R input streams and AXI B/R output channels.
// Modports:
//   slave  - adapter side: consumes ar_*/dec_*/xready, drives ar_allow, dec_xready, AXI B/R.
//   master - environment side: the mirror image.
interface munoc_mni_resp_axi_adapter_if #(
  parameter int BW_ID   = 4,
  parameter int BW_DATA = 32,
  parameter int BW_LEN  = 8
);
  logic               ar_fire;
  logic [BW_LEN-1:0]  ar_len;
  logic               ar_allow;

  logic               dec_bvalid;
  logic               dec_bready;
  logic [BW_ID-1:0]   dec_bid;
  logic [1:0]         dec_bresp;

  logic               dec_rvalid;
  logic               dec_rready;
  logic [BW_ID-1:0]   dec_rid;
  logic [1:0]         dec_rresp;
  logic [BW_DATA-1:0] dec_rdata;

  logic               bvalid;
  logic               bready;
  logic [BW_ID-1:0]   bid;
  logic [1:0]         bresp;

  logic               rvalid;
  logic               rready;
  logic [BW_ID-1:0]   rid;
  logic [1:0]         rresp;
  logic [BW_DATA-1:0] rdata;
  logic               rlast;

  modport slave (
    input  ar_fire, ar_len,
    input  dec_bvalid, dec_bid, dec_bresp,
    input  dec_rvalid, dec_rid, dec_rresp, dec_rdata,
    input  bready, rready,
    output ar_allow, dec_bready, dec_rready,
    output bvalid, bid, bresp,
    output rvalid, rid, rresp, rdata, rlast
  );

  modport master (
    output ar_fire, ar_len,
    output dec_bvalid, dec_bid, dec_bresp,
    output dec_rvalid, dec_rid, dec_rresp, dec_rdata,
    output bready, rready,
    input  ar_allow, dec_bready, dec_rready,
    input  bvalid, bid, bresp,
    input  rvalid, rid, rresp, rdata, rlast
  );
endinterface

// File: rtl/munoc_mni_resp_axi_adapter.sv
// rtl/munoc_mni_resp_axi_adapter.sv - decoded NoC B/R responses to AXI B/R with RLAST generation
// Purpose: 2-entry skid slice per channel, AR burst-length FIFO, per-burst beat counter for RLAST.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   bus (slave)     - ar_fire/ar_len/ar_allow, dec_b*/dec_r* inputs, AXI B and R channels
//   proto_err_o     - sticky: R beat accepted while the length FIFO was empty
//   err_clr_i, err_cnt_o - only with MUNOC_RESP_ADAPTER_ERRCNT_EN: error-response counter
module munoc_mni_resp_axi_adapter #(
  parameter int BW_ID     = 4,
  parameter int BW_DATA   = 32,
  parameter int BW_LEN    = 8,
  parameter int LEN_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  munoc_mni_resp_axi_adapter_if.slave bus,
  output logic proto_err_o
`ifdef MUNOC_RESP_ADAPTER_ERRCNT_EN
  ,
  input  logic        err_clr_i,
  output logic [15:0] err_cnt_o
`endif
);
  localparam int PW    = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
  localparam int BW_BE = BW_ID + 2;
  localparam int BW_RE = BW_ID + 2 + BW_DATA + 1;
  localparam logic [PW:0] LEN_CNT_FULL = (PW+1)'(LEN_DEPTH);

  // ---------------- B skid slice ----------------
  logic [BW_BE-1:0] b_mem_q [2];
  logic             b_wp_q, b_rp_q;
  logic [1:0]       b_cnt_q, b_cnt_d;
  logic             b_acc, b_drn;
  logic [BW_BE-1:0] b_head;

  always_comb begin
    b_acc   = bus.dec_bvalid && (b_cnt_q != 2'd2);
    b_drn   = (b_cnt_q != 2'd0) && bus.bready;
    b_cnt_d = b_cnt_q + 2'(b_acc) - 2'(b_drn);
  end

  always_ff @(posedge clk) begin
    if (b_acc) b_mem_q[b_wp_q] <= {bus.dec_bid, bus.dec_bresp};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_wp_q  <= 1'b0;
      b_rp_q  <= 1'b0;
      b_cnt_q <= 2'd0;
    end else begin
      if (b_acc) b_wp_q <= ~b_wp_q;
      if (b_drn) b_rp_q <= ~b_rp_q;
      b_cnt_q <= b_cnt_d;
    end
  end

  // Ready depends only on registered occupancy, never on bready.
  assign bus.dec_bready = (b_cnt_q != 2'd2);
  assign bus.bvalid     = (b_cnt_q != 2'd0);
  assign b_head         = b_mem_q[b_rp_q];
  assign bus.bid        = b_head[BW_BE-1:2];
  assign bus.bresp      = b_head[1:0];

  // ---------------- R skid slice ----------------
  logic [BW_RE-1:0] r_mem_q [2];
  logic             r_wp_q, r_rp_q;
  logic [1:0]       r_cnt_q, r_cnt_d;
  logic             r_acc, r_drn;
  logic [BW_RE-1:0] r_head;

  // ---------------- Length FIFO / beat counter ----------------
  logic [BW_LEN-1:0] len_mem_q [LEN_DEPTH];
  logic [PW-1:0]     len_wp_q, len_rp_q;
  logic [PW:0]       len_cnt_q, len_cnt_d;
  logic              len_full, len_empty, len_push, len_pop, r_last;
  logic [BW_LEN-1:0] beat_cnt_q, beat_cnt_d;
  logic              proto_err_q, proto_err_d;

  always_comb begin
    r_acc      = bus.dec_rvalid && (r_cnt_q != 2'd2);
    r_drn      = (r_cnt_q != 2'd0) && bus.rready;
    r_cnt_d    = r_cnt_q + 2'(r_acc) - 2'(r_drn);

    len_full   = (len_cnt_q == LEN_CNT_FULL);
    len_empty  = (len_cnt_q == '0);
    // With no outstanding AR the beat is closed off on its own and flagged.
    r_last     = len_empty || (beat_cnt_q == len_mem_q[len_rp_q]);
    len_pop    = r_acc && r_last && !len_empty;
    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    len_push   = bus.ar_fire && (!len_full || len_pop);
    len_cnt_d  = len_cnt_q + (PW+1)'(len_push) - (PW+1)'(len_pop);

    beat_cnt_d = beat_cnt_q;
    if (r_acc) beat_cnt_d = r_last ? '0 : beat_cnt_q + BW_LEN'(1);

    proto_err_d = proto_err_q || (r_acc && len_empty);
  end

  always_ff @(posedge clk) begin
    if (r_acc) r_mem_q[r_wp_q] <= {bus.dec_rid, bus.dec_rresp, bus.dec_rdata, r_last};
    if (len_push) len_mem_q[len_wp_q] <= bus.ar_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp_q      <= 1'b0;
      r_rp_q      <= 1'b0;
      r_cnt_q     <= 2'd0;
      len_wp_q    <= '0;
      len_rp_q    <= '0;
      len_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (r_acc) r_wp_q <= ~r_wp_q;
      if (r_drn) r_rp_q <= ~r_rp_q;
      r_cnt_q <= r_cnt_d;
      // LEN_DEPTH is a power of 2, so pointers wrap naturally.
      if (len_push) len_wp_q <= len_wp_q + PW'(1);
      if (len_pop)  len_rp_q <= len_rp_q + PW'(1);
      len_cnt_q   <= len_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.dec_rready = (r_cnt_q != 2'd2);
  assign bus.rvalid     = (r_cnt_q != 2'd0);
  assign r_head         = r_mem_q[r_rp_q];
  assign bus.rid        = r_head[BW_RE-1 -: BW_ID];
  assign bus.rresp      = r_head[BW_DATA+2 -: 2];
  assign bus.rdata      = r_head[BW_DATA:1];
  assign bus.rlast      = r_head[0];
  assign bus.ar_allow   = !len_full;
  assign proto_err_o    = proto_err_q;

`ifdef MUNOC_RESP_ADAPTER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  always_comb begin
    err_inc = 2'(bus.bvalid && bus.bready && b_head[1])
            + 2'(bus.rvalid && bus.rready && r_head[BW_DATA+2]);
    err_sum = {1'b0, err_cnt_q} + 17'(err_inc);
    if (err_clr_i)       err_cnt_d = '0;
    else if (err_sum[16]) err_cnt_d = 16'hFFFF;
    else                  err_cnt_d = err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_munoc_mni_resp_axi_adapter.sv
// tb/tb_munoc_mni_resp_axi_adapter.sv - self-checking bench for munoc_mni_resp_axi_adapter
module tb_munoc_mni_resp_axi_adapter;
  logic clk = 1'b0;
  logic rst;
  logic proto_err;
`ifdef MUNOC_RESP_ADAPTER_ERRCNT_EN
  logic        err_clr;
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  munoc_mni_resp_axi_adapter_if #(.BW_ID(4), .BW_DATA(32), .BW_LEN(8)) bus ();

  munoc_mni_resp_axi_adapter #(.BW_ID(4), .BW_DATA(32), .BW_LEN(8), .LEN_DEPTH(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .proto_err_o (proto_err)
`ifdef MUNOC_RESP_ADAPTER_ERRCNT_EN
    ,
    .err_clr_i   (err_clr),
    .err_cnt_o   (err_cnt)
`endif
  );

  typedef struct {
    logic        do_ar;
    logic [7:0]  ar_len;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
    logic        exp_last;
  } rvec_t;

  rvec_t       vecs [7];
  logic [38:0] r_exp_q [$];
  logic [5:0]  b_exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ar_fire = 0; bus.ar_len = '0;
    bus.dec_bvalid = 0; bus.dec_bid = '0; bus.dec_bresp = '0;
    bus.dec_rvalid = 0; bus.dec_rid = '0; bus.dec_rresp = '0; bus.dec_rdata = '0;
    bus.bready = 1; bus.rready = 1;
`ifdef MUNOC_RESP_ADAPTER_ERRCNT_EN
    err_clr = 0;
`endif
    step();
    step();
    rst = 1'b0;
    r_exp_q.delete();
    b_exp_q.delete();
  endtask

  task automatic do_ar(input logic [7:0] len);
    bus.ar_fire = 1; bus.ar_len = len;
    step();
    bus.ar_fire = 0;
  endtask

  task automatic send_r(input logic [3:0] id, input logic [1:0] resp, input logic [31:0] data,
                        input logic last);
    bit done = 0;
    bus.dec_rvalid = 1; bus.dec_rid = id; bus.dec_rresp = resp; bus.dec_rdata = data;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.dec_rready) begin
        r_exp_q.push_back({id, resp, data, last});
        done = 1;
      end
      step();
    end
    bus.dec_rvalid = 0;
    if (!done) fail_now("r_accept");
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
    bit done = 0;
    bus.dec_bvalid = 1; bus.dec_bid = id; bus.dec_bresp = resp;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.dec_bready) begin
        b_exp_q.push_back({id, resp});
        done = 1;
      end
      step();
    end
    bus.dec_bvalid = 0;
    if (!done) fail_now("b_accept");
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (r_exp_q.size() == 0 && b_exp_q.size() == 0 && !bus.rvalid && !bus.bvalid) done = 1;
      step();
    end
    if (!done) fail_now("drain");
  endtask

  // Scoreboard: compare every delivered beat against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rvalid && bus.rready) begin
        if (r_exp_q.size() == 0) fail_now("r_unexpected");
        else check("r_beat", {bus.rid, bus.rresp, bus.rdata, bus.rlast}, r_exp_q.pop_front());
      end
      if (bus.bvalid && bus.bready) begin
        if (b_exp_q.size() == 0) fail_now("b_unexpected");
        else check("b_beat", {bus.bid, bus.bresp}, b_exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'd3, 4'h1, 2'b00, 32'hA000_0000, 1'b0};
    vecs[1] = '{1'b0, 8'd0, 4'h1, 2'b00, 32'hA000_0001, 1'b0};
    vecs[2] = '{1'b0, 8'd0, 4'h1, 2'b00, 32'hA000_0002, 1'b0};
    vecs[3] = '{1'b0, 8'd0, 4'h1, 2'b00, 32'hA000_0003, 1'b1};
    vecs[4] = '{1'b1, 8'd0, 4'h2, 2'b00, 32'hB000_0000, 1'b1};
    vecs[5] = '{1'b1, 8'd1, 4'h3, 2'b00, 32'hC000_0000, 1'b0};
    vecs[6] = '{1'b0, 8'd0, 4'h3, 2'b10, 32'hC000_0001, 1'b1};

    do_reset();
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_ar_allow", bus.ar_allow, 1);
    check("rst_dec_rready", bus.dec_rready, 1);
    check("rst_dec_bready", bus.dec_bready, 1);

    // Table-driven bursts: lengths 3, 0, 1.
    foreach (vecs[i]) begin
      if (vecs[i].do_ar) do_ar(vecs[i].ar_len);
      send_r(vecs[i].id, vecs[i].resp, vecs[i].data, vecs[i].exp_last);
      check("tbl_ar_allow", bus.ar_allow, 1);
    end
    wait_drain();
    check("tbl_proto_err", proto_err, 0);

    // B channel, including backpressure.
    send_b(4'h5, 2'b00);
    send_b(4'h6, 2'b01);
    wait_drain();
    bus.bready = 0;
    send_b(4'h7, 2'b10);
    send_b(4'h8, 2'b11);
    @(negedge clk);
    check("b_full_ready", bus.dec_bready, 0);
    step();
    bus.bready = 1;
    wait_drain();

    // FIFO fill to full, single pop frees a slot.
    for (int k = 0; k < 4; k++) begin
      do_ar(8'd0);
      check("fill_ar_allow", bus.ar_allow, (k < 3) ? 1 : 0);
    end
    send_r(4'h9, 2'b00, 32'hD000_0000, 1'b1);
    check("pop_ar_allow", bus.ar_allow, 1);
    for (int k = 1; k < 4; k++) send_r(4'h9, 2'b00, 32'hD000_0000 + k, 1'b1);
    wait_drain();

    // Full FIFO: push coincides with last-beat pop.
    for (int k = 0; k < 4; k++) do_ar(8'd0);
    check("full_ar_allow", bus.ar_allow, 0);
    bus.ar_fire = 1; bus.ar_len = 8'd2;
    send_r(4'hA, 2'b00, 32'hE000_0000, 1'b1);
    bus.ar_fire = 0;
    check("pushpop_ar_allow", bus.ar_allow, 0);
    send_r(4'hA, 2'b00, 32'hE000_0001, 1'b1);
    check("after_pop_ar_allow", bus.ar_allow, 1);
    send_r(4'hA, 2'b00, 32'hE000_0002, 1'b1);
    send_r(4'hA, 2'b00, 32'hE000_0003, 1'b1);
    send_r(4'hB, 2'b00, 32'hE100_0000, 1'b0);
    send_r(4'hB, 2'b00, 32'hE100_0001, 1'b0);
    send_r(4'hB, 2'b00, 32'hE100_0002, 1'b1);
    wait_drain();

    // R backpressure: slice fills at 2, output holds stable.
    do_ar(8'd2);
    bus.rready = 0;
    send_r(4'hC, 2'b00, 32'hF000_0000, 1'b0);
    send_r(4'hC, 2'b00, 32'hF000_0001, 1'b0);
    bus.dec_rvalid = 1; bus.dec_rid = 4'hC; bus.dec_rresp = 2'b00; bus.dec_rdata = 32'hF000_0002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_dec_rready", bus.dec_rready, 0);
      check("bp_rdata_stable", bus.rdata, 32'hF000_0000);
      step();
    end
    bus.rready = 1;
    send_r(4'hC, 2'b00, 32'hF000_0002, 1'b1);
    wait_drain();

    // R beat with no outstanding AR.
    do_reset();
    send_r(4'hD, 2'b00, 32'h1234_5678, 1'b1);
    check("orphan_proto_err", proto_err, 1);
    do_ar(8'd1);
    send_r(4'hD, 2'b00, 32'h1234_5679, 1'b0);
    send_r(4'hD, 2'b00, 32'h1234_567A, 1'b1);
    wait_drain();
    check("sticky_proto_err", proto_err, 1);
    do_reset();
    check("cleared_proto_err", proto_err, 0);

`ifdef MUNOC_RESP_ADAPTER_ERRCNT_EN
    bus.bready = 0; bus.rready = 0;
    do_ar(8'd0);
    send_b(4'h1, 2'b10);
    send_r(4'h2, 2'b11, 32'h5555_0000, 1'b1);
    check("err_cnt_held", err_cnt, 0);
    bus.bready = 1; bus.rready = 1;
    step();
    check("err_cnt_two", err_cnt, 2);
    wait_drain();
    bus.bready = 0;
    send_b(4'h3, 2'b10);
    bus.bready = 1; err_clr = 1;
    step();
    err_clr = 0;
    check("err_cnt_clr_prio", err_cnt, 0);
    wait_drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
